// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI master.
package spi_pkg;

    localparam int unsigned CLKS_PER_HALF_BIT_DEFAULT = 4;
    localparam int unsigned EDGE_TOTAL                = 16;
    localparam int unsigned HALF_CNT_W                = 4;
    localparam int unsigned EDGE_CNT_W                = 4;
    localparam int unsigned BYTE_W                    = 8;
    localparam int unsigned COUNT_W                   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-period timing, edge sequencing and SCLK level.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLKS_PER_HALF_BIT = CLKS_PER_HALF_BIT_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic start_c,
    input  logic busy,
    input  logic clk_pol,
    output logic spi_clk_c,
    output logic leading_edge,
    output logic trailing_edge,
    output logic lead_c,
    output logic trail_c,
    output logic done_c
);

    localparam logic [HALF_CNT_W-1:0] HALF_LAST = HALF_CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [EDGE_CNT_W-1:0] EDGE_LAST = EDGE_CNT_W'(EDGE_TOTAL - 1);

    logic [HALF_CNT_W-1:0] half_cnt;
    logic [EDGE_CNT_W-1:0] edge_cnt;
    logic                  phase;
    logic                  cpol_q;
    logic                  tick_c;

    // Edge strobes for the cycle ending at the next rising sys_clk edge.
    always_comb begin
        tick_c  = busy && (half_cnt == HALF_LAST);
        lead_c  = tick_c && !edge_cnt[0];
        trail_c = tick_c &&  edge_cnt[0];
        done_c  = trail_c && (edge_cnt == EDGE_LAST);
    end

    // Idle level tracks the live polarity; a transfer uses the captured one.
    assign spi_clk_c = busy ? (cpol_q ^ phase) : clk_pol;

    // Half-period and edge counters, SCLK phase and registered edge pulses.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            half_cnt      <= '0;
            edge_cnt      <= '0;
            phase         <= 1'b0;
            cpol_q        <= 1'b0;
            leading_edge  <= 1'b0;
            trailing_edge <= 1'b0;
        end else begin
            leading_edge  <= lead_c;
            trailing_edge <= trail_c;
            if (start_c) begin
                half_cnt <= '0;
                edge_cnt <= '0;
                phase    <= 1'b0;
                cpol_q   <= clk_pol;
            end else if (busy) begin
                if (tick_c) begin
                    half_cnt <= '0;
                    edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
                    phase    <= lead_c;
                end else begin
                    half_cnt <= half_cnt + HALF_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master, CPHA=0: one byte per i_tx_vd, MSB first, full duplex.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLKS_PER_HALF_BIT = CLKS_PER_HALF_BIT_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                i_miso,
    input  logic                i_tx_vd,
    input  logic                i_clk_pol,
    input  logic [BYTE_W-1:0]   i_tx_parallel,
    output logic [BYTE_W-1:0]   o_rx_parallel,
    output logic                o_mosi,
    output logic                o_spi_clk,
    output logic                o_tx_slv_ready,
    output logic                o_tx_device_ready,
    output logic                o_leading_edge,
    output logic                o_trailing_edge,
    output logic [COUNT_W-1:0]  o_bit_count,
    output logic [COUNT_W-1:0]  o_byte_count
);

    state_t               state_q, state_d;
    logic [BYTE_W-2:0]    tx_shift_q, tx_shift_d;
    logic [BYTE_W-1:0]    rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]    rx_par_d;
    logic                 mosi_d;
    logic                 slv_ready_d;
    logic                 dev_ready_d;
    logic [COUNT_W-1:0]   bit_count_d;
    logic [COUNT_W-1:0]   byte_count_d;
    logic                 start_c;
    logic                 lead_c;
    logic                 trail_c;
    logic                 done_c;

    assign start_c = i_tx_vd && o_tx_device_ready;

    spi_clk_gen #(
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_clk_gen (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .start_c       (start_c),
        .busy          (state_q == XFER),
        .clk_pol       (i_clk_pol),
        .spi_clk_c     (o_spi_clk),
        .leading_edge  (o_leading_edge),
        .trailing_edge (o_trailing_edge),
        .lead_c        (lead_c),
        .trail_c       (trail_c),
        .done_c        (done_c)
    );

    // Next-state and datapath: capture at start, sample on leading, shift on trailing.
    always_comb begin
        state_d      = state_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        rx_par_d     = o_rx_parallel;
        mosi_d       = o_mosi;
        slv_ready_d  = 1'b0;
        dev_ready_d  = o_tx_device_ready;
        bit_count_d  = o_bit_count;
        byte_count_d = o_byte_count;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d     = XFER;
                    dev_ready_d = 1'b0;
                    mosi_d      = i_tx_parallel[BYTE_W-1];
                    tx_shift_d  = i_tx_parallel[BYTE_W-2:0];
                end
            end
            XFER: begin
                if (lead_c) begin
                    rx_shift_d  = {rx_shift_q[BYTE_W-2:0], i_miso};
                    bit_count_d = o_bit_count + COUNT_W'(1);
                end
                if (done_c) begin
                    state_d      = IDLE;
                    rx_par_d     = rx_shift_q;
                    slv_ready_d  = 1'b1;
                    dev_ready_d  = 1'b1;
                    byte_count_d = o_byte_count + COUNT_W'(1);
                end else if (trail_c) begin
                    mosi_d     = tx_shift_q[BYTE_W-2];
                    tx_shift_d = {tx_shift_q[BYTE_W-3:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q           <= IDLE;
            tx_shift_q        <= '0;
            rx_shift_q        <= '0;
            o_rx_parallel     <= '0;
            o_mosi            <= 1'b0;
            o_tx_slv_ready    <= 1'b0;
            o_tx_device_ready <= 1'b1;
            o_bit_count       <= '0;
            o_byte_count      <= '0;
        end else begin
            state_q           <= state_d;
            tx_shift_q        <= tx_shift_d;
            rx_shift_q        <= rx_shift_d;
            o_rx_parallel     <= rx_par_d;
            o_mosi            <= mosi_d;
            o_tx_slv_ready    <= slv_ready_d;
            o_tx_device_ready <= dev_ready_d;
            o_bit_count       <= bit_count_d;
            o_byte_count      <= byte_count_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master against a timeline model.
module tb_spi_master;

    localparam int H    = 4;
    localparam int XLEN = 16 * H;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       i_miso;
    logic       i_tx_vd;
    logic       i_clk_pol;
    logic [7:0] i_tx_parallel;
    logic [7:0] o_rx_parallel;
    logic       o_mosi;
    logic       o_spi_clk;
    logic       o_tx_slv_ready;
    logic       o_tx_device_ready;
    logic       o_leading_edge;
    logic       o_trailing_edge;
    logic [2:0] o_bit_count;
    logic [2:0] o_byte_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_byte = 0;
    logic [7:0] exp_rx = 8'h00;

    spi_master #(
        .CLKS_PER_HALF_BIT (H)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .i_miso            (i_miso),
        .i_tx_vd           (i_tx_vd),
        .i_clk_pol         (i_clk_pol),
        .i_tx_parallel     (i_tx_parallel),
        .o_rx_parallel     (o_rx_parallel),
        .o_mosi            (o_mosi),
        .o_spi_clk         (o_spi_clk),
        .o_tx_slv_ready    (o_tx_slv_ready),
        .o_tx_device_ready (o_tx_device_ready),
        .o_leading_edge    (o_leading_edge),
        .o_trailing_edge   (o_trailing_edge),
        .o_bit_count       (o_bit_count),
        .o_byte_count      (o_byte_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_spi_clk", 32'(o_spi_clk), 32'(i_clk_pol));
        check("rst_ready", 32'(o_tx_device_ready), 32'd1);
        check("rst_rx", 32'(o_rx_parallel), 32'd0);
        check("rst_mosi", 32'(o_mosi), 32'd0);
        check("rst_slv_ready", 32'(o_tx_slv_ready), 32'd0);
        check("rst_lead", 32'(o_leading_edge), 32'd0);
        check("rst_trail", 32'(o_trailing_edge), 32'd0);
        check("rst_bit_count", 32'(o_bit_count), 32'd0);
        check("rst_byte_count", 32'(o_byte_count), 32'd0);
    endtask

    // Idle cycles: SCLK follows live polarity, no pulses, counts and data held.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
            check("idle_spi_clk", 32'(o_spi_clk), 32'(i_clk_pol));
            check("idle_ready", 32'(o_tx_device_ready), 32'd1);
            check("idle_pulses", 32'({o_leading_edge, o_trailing_edge, o_tx_slv_ready}), 32'd0);
            check("idle_rx", 32'(o_rx_parallel), 32'(exp_rx));
            check("idle_counts", 32'({o_bit_count, o_byte_count}), 32'({3'd0, 3'(exp_byte)}));
            i_clk_pol = 1'($urandom_range(0, 1));
            #1;
            check("idle_pol_follow", 32'(o_spi_clk), 32'(i_clk_pol));
        end
    endtask

    // One byte transfer; the cycle after T0 is t=0, completion is t=XLEN.
    task automatic run_byte(input logic [7:0] tx, input logic [7:0] miso, input logic cpol,
                            input int inject_t, input int rst_t, input bit wiggle);
        int waited = 0;
        int n_lead = 0;
        int n_trail = 0;
        int idx;
        int ph;
        int nxt_byte;
        logic exp_clk;
        logic exp_le;
        logic exp_te;
        while (!o_tx_device_ready && waited < 200) begin
            @(posedge sys_clk);
            #1;
            waited++;
        end
        if (!o_tx_device_ready) begin
            check("ready_wait_timeout", 32'(o_tx_device_ready), 32'd1);
            return;
        end
        i_tx_parallel = tx;
        i_clk_pol     = cpol;
        i_tx_vd       = 1'b1;
        nxt_byte      = (exp_byte + 1) % 8;
        for (int t = 0; t <= XLEN; t++) begin
            @(posedge sys_clk);
            #1;
            if (t == 0) i_tx_vd = 1'b0;
            idx     = (t / (2 * H) > 7) ? 7 : t / (2 * H);
            ph      = (t / H) % 2;
            exp_clk = (t < XLEN) ? (cpol ^ 1'(ph)) : i_clk_pol;
            exp_le  = (t > 0) && (t % H == 0) && (ph == 1);
            exp_te  = (t > 0) && (t % H == 0) && (ph == 0);
            check("mosi", 32'(o_mosi), 32'(tx[7 - idx]));
            check("spi_clk", 32'(o_spi_clk), 32'(exp_clk));
            check("lead", 32'(o_leading_edge), 32'(exp_le));
            check("trail", 32'(o_trailing_edge), 32'(exp_te));
            check("ready", 32'(o_tx_device_ready), 32'(t == XLEN));
            check("slv_ready", 32'(o_tx_slv_ready), 32'(t == XLEN));
            check("bit_count", 32'(o_bit_count), 32'(((t / H + 1) / 2) % 8));
            check("byte_count", 32'(o_byte_count), 32'((t == XLEN) ? nxt_byte : exp_byte));
            check("rx_parallel", 32'(o_rx_parallel), 32'((t == XLEN) ? miso : exp_rx));
            if (o_leading_edge)  n_lead++;
            if (o_trailing_edge) n_trail++;
            if (t == rst_t) begin
                sys_rst = 1'b0;
                #1;
                exp_byte = 0;
                exp_rx   = 8'h00;
                check_reset_outputs();
                @(negedge sys_clk);
                sys_rst = 1'b1;
                return;
            end
            i_miso = miso[7 - idx];
            if (t == inject_t)     i_tx_vd = 1'b1;
            if (t == inject_t + 1) i_tx_vd = 1'b0;
            if (wiggle && t < XLEN) i_clk_pol = 1'($urandom_range(0, 1));
        end
        check("lead_pulses", 32'(n_lead), 32'd8);
        check("trail_pulses", 32'(n_trail), 32'd8);
        exp_byte = nxt_byte;
        exp_rx   = miso;
    endtask

    initial begin
        sys_rst       = 1'b0;
        i_miso        = 1'b0;
        i_tx_vd       = 1'b0;
        i_clk_pol     = 1'b1;
        i_tx_parallel = 8'h00;
        #12;
        check_reset_outputs();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        idle_cycles(3);

        run_byte(8'hAA, 8'hAA, 1'b1, -10, -1, 1'b0);
        idle_cycles(2);
        run_byte(8'h3C, 8'hFF, 1'b0, -10, -1, 1'b0);
        idle_cycles(2);

        run_byte(8'h5A, 8'h81, 1'b1, -10, 30, 1'b0);
        idle_cycles(3);

        run_byte(8'hC3, 8'h66, 1'b0, 20, -1, 1'b0);
        idle_cycles(2);

        for (int b = 0; b < 9; b++) begin
            run_byte(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), -10, -1, 1'b0);
        end
        idle_cycles(2);

        for (int r = 0; r < 6; r++) begin
            run_byte(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), -10, -1, 1'b1);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
